// File: rtl/dbus_ctrl.sv
// rtl/dbus_ctrl.sv - data-bus controller: address decode, chip selects, wait states, CPU handshake
module dbus_ctrl #(
    parameter logic [31:0] DMEM_BASE   = 32'h0000_0000,
    parameter logic [31:0] DMEM_MASK   = 32'hFFFF_C000,
    parameter logic [31:0] TBMAN_BASE  = 32'h8000_0000,
    parameter logic [31:0] TIMER_BASE  = 32'h8000_1000,
    parameter logic [31:0] PERIPH_MASK = 32'hFFFF_F000,
    parameter int unsigned DMEM_WS     = 0,
    parameter int unsigned TBMAN_WS    = 1,
    parameter int unsigned TIMER_WS    = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    input  logic [3:0]  i_cpu_be,
    output logic        o_cpu_ready,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_err,
    output logic        o_cs_dmem_n,
    output logic        o_cs_tbman_n,
    output logic        o_cs_timer_n,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic [31:0] i_read_data_dmem,
    input  logic [31:0] i_read_data_tbman,
    input  logic [31:0] i_read_data_timer
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [1:0] T_DMEM  = 2'd0;
    localparam logic [1:0] T_TBMAN = 2'd1;
    localparam logic [1:0] T_TIMER = 2'd2;

    // Wait-state counts wrap modulo 16 to fit the counter.
    localparam logic [3:0] DMEM_WS4  = DMEM_WS[3:0];
    localparam logic [3:0] TBMAN_WS4 = TBMAN_WS[3:0];
    localparam logic [3:0] TIMER_WS4 = TIMER_WS[3:0];

    state_t      r_state;
    logic [1:0]  r_tgt;
    logic [3:0]  r_cnt;
    logic        r_ready;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_cs_dmem_n;
    logic        r_cs_tbman_n;
    logic        r_cs_timer_n;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_be;

    logic        w_hit_dmem;
    logic        w_hit_tbman;
    logic        w_hit_timer;
    logic [31:0] w_rd_data;

    assign w_hit_dmem  = (i_cpu_addr & DMEM_MASK)   == DMEM_BASE;
    assign w_hit_tbman = (i_cpu_addr & PERIPH_MASK) == TBMAN_BASE;
    assign w_hit_timer = (i_cpu_addr & PERIPH_MASK) == TIMER_BASE;

    always_comb begin
        w_rd_data = 32'h0;
        case (r_tgt)
            T_DMEM:  w_rd_data = i_read_data_dmem;
            T_TBMAN: w_rd_data = i_read_data_tbman;
            T_TIMER: w_rd_data = i_read_data_timer;
            default: w_rd_data = 32'h0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_tgt        <= T_DMEM;
            r_cnt        <= 4'd0;
            r_ready      <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= 32'h0;
            r_cs_dmem_n  <= 1'b1;
            r_cs_tbman_n <= 1'b1;
            r_cs_timer_n <= 1'b1;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= 32'h0;
            r_bus_wdata  <= 32'h0;
            r_bus_be     <= 4'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    if (i_cpu_req) begin
                        r_bus_addr  <= i_cpu_addr;
                        r_bus_wdata <= i_cpu_wdata;
                        r_bus_be    <= i_cpu_be;
                        if (w_hit_dmem) begin
                            r_tgt       <= T_DMEM;
                            r_cnt       <= DMEM_WS4;
                            r_cs_dmem_n <= 1'b0;
                            r_bus_we    <= i_cpu_we;
                            r_state     <= S_ACCESS;
                        end else if (w_hit_tbman) begin
                            r_tgt        <= T_TBMAN;
                            r_cnt        <= TBMAN_WS4;
                            r_cs_tbman_n <= 1'b0;
                            r_bus_we     <= i_cpu_we;
                            r_state      <= S_ACCESS;
                        end else if (w_hit_timer) begin
                            r_tgt        <= T_TIMER;
                            r_cnt        <= TIMER_WS4;
                            r_cs_timer_n <= 1'b0;
                            r_bus_we     <= i_cpu_we;
                            r_state      <= S_ACCESS;
                        end else begin
                            r_err   <= 1'b1;
                            r_rdata <= 32'h0;
                            r_ready <= 1'b1;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Writes return zero so stale read data never looks valid.
                        r_rdata      <= r_bus_we ? 32'h0 : w_rd_data;
                        r_cs_dmem_n  <= 1'b1;
                        r_cs_tbman_n <= 1'b1;
                        r_cs_timer_n <= 1'b1;
                        r_bus_we     <= 1'b0;
                        r_ready      <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cpu_ready  = r_ready;
    assign o_cpu_rdata  = r_rdata;
    assign o_cpu_err    = r_err;
    assign o_cs_dmem_n  = r_cs_dmem_n;
    assign o_cs_tbman_n = r_cs_tbman_n;
    assign o_cs_timer_n = r_cs_timer_n;
    assign o_bus_we     = r_bus_we;
    assign o_bus_addr   = r_bus_addr;
    assign o_bus_wdata  = r_bus_wdata;
    assign o_bus_be     = r_bus_be;

endmodule

// File: tb/tb_dbus_ctrl.sv
// tb/tb_dbus_ctrl.sv - directed self-checking bench for dbus_ctrl
module tb_dbus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        cs_dmem_n;
    logic        cs_tbman_n;
    logic        cs_timer_n;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] rd_dmem  = 32'hDEAD_BEEF;
    logic [31:0] rd_tbman = 32'h5555_0001;
    logic [31:0] rd_timer = 32'h0000_1234;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_ready;
    int first_ready;

    dbus_ctrl dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_cpu_req         (cpu_req),
        .i_cpu_we          (cpu_we),
        .i_cpu_addr        (cpu_addr),
        .i_cpu_wdata       (cpu_wdata),
        .i_cpu_be          (cpu_be),
        .o_cpu_ready       (cpu_ready),
        .o_cpu_rdata       (cpu_rdata),
        .o_cpu_err         (cpu_err),
        .o_cs_dmem_n       (cs_dmem_n),
        .o_cs_tbman_n      (cs_tbman_n),
        .o_cs_timer_n      (cs_timer_n),
        .o_bus_we          (bus_we),
        .o_bus_addr        (bus_addr),
        .o_bus_wdata       (bus_wdata),
        .o_bus_be          (bus_be),
        .i_read_data_dmem  (rd_dmem),
        .i_read_data_tbman (rd_tbman),
        .i_read_data_timer (rd_timer)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // tgt: 0 dmem, 1 tbman, 2 timer, 3 unmapped
    task automatic do_access(input string tag, input logic [31:0] addr, input logic we,
                             input logic [31:0] wdata, input logic [3:0] be, input int tgt,
                             input int ws, input logic [31:0] exp_rdata, input logic exp_err,
                             input bit hold);
        int k;
        int cs_cnt;
        int wrong_cs;
        int multi;
        int bad_we;
        bit got;
        logic [2:0] cs;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_be    = be;
        @(posedge clk); #1;
        k = 1; got = 0; cs_cnt = 0; wrong_cs = 0; multi = 0; bad_we = 0;
        while (!got && k <= 40) begin
            cs = {cs_timer_n, cs_tbman_n, cs_dmem_n};
            if (int'(!cs[0]) + int'(!cs[1]) + int'(!cs[2]) > 1) multi++;
            for (int t = 0; t < 3; t++) begin
                if (!cs[t]) begin
                    if (t == tgt) begin
                        cs_cnt++;
                        if (bus_we !== we) bad_we++;
                    end else begin
                        wrong_cs++;
                    end
                end
            end
            if (cpu_ready) got = 1;
            else begin
                @(posedge clk); #1;
                k++;
            end
        end
        chk({tag, "_ready_latency"}, k, (tgt == 3) ? 1 : ws + 2);
        chk({tag, "_cs_cycles"}, cs_cnt, (tgt == 3) ? 0 : ws + 1);
        chk({tag, "_wrong_cs"}, wrong_cs, 0);
        chk({tag, "_multi_cs"}, multi, 0);
        chk({tag, "_bus_we"}, bad_we, 0);
        chk({tag, "_rdata"}, cpu_rdata, exp_rdata);
        chk({tag, "_err"}, cpu_err, exp_err);
        chk({tag, "_bus_addr"}, bus_addr, addr);
        chk({tag, "_bus_wdata"}, bus_wdata, wdata);
        chk({tag, "_bus_be"}, bus_be, be);
        chk({tag, "_resp_cs"}, {cs_timer_n, cs_tbman_n, cs_dmem_n, bus_we}, 4'b1110);
        last_ready = cyc;
        if (!hold) cpu_req = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_ready_pulse"}, {cpu_ready, cpu_err}, 2'b00);
        chk({tag, "_rdata_hold"}, cpu_rdata, exp_rdata);
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_be = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cs", {cs_timer_n, cs_tbman_n, cs_dmem_n}, 3'b111);
        chk("reset_resp", {cpu_ready, cpu_err, bus_we}, 3'b000);
        chk("reset_rdata", cpu_rdata, 32'h0);
        chk("reset_bus", {bus_addr, bus_wdata}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        do_access("dmem_rd", 32'h0000_0010, 1'b0, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0, 0);
        do_access("timer_rd", 32'h8000_1004, 1'b0, 32'h0, 4'hF, 2, 2, 32'h0000_1234, 1'b0, 0);
        do_access("tbman_wr", 32'h8000_0000, 1'b1, 32'hA5A5_A5A5, 4'hF, 1, 1, 32'h0, 1'b0, 0);
        do_access("unmapped", 32'h4000_0000, 1'b0, 32'h0, 4'h3, 3, 0, 32'h0, 1'b1, 0);
        do_access("dmem_top", 32'h0000_3FFC, 1'b0, 32'h0, 4'h1, 0, 0, 32'hDEAD_BEEF, 1'b0, 0);
        do_access("dmem_past", 32'h0000_4000, 1'b0, 32'h0, 4'hF, 3, 0, 32'h0, 1'b1, 0);
        do_access("tbman_rd", 32'h8000_0FFC, 1'b0, 32'h0, 4'hF, 1, 1, 32'h5555_0001, 1'b0, 0);

        // Back-to-back with cpu_req held high throughout.
        do_access("b2b_dmem", 32'h0000_0020, 1'b0, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0, 1);
        first_ready = last_ready;
        do_access("b2b_timer", 32'h8000_1008, 1'b0, 32'h0, 4'hF, 2, 2, 32'h0000_1234, 1'b0, 0);
        chk("b2b_spacing", last_ready - first_ready, 5);

        // Reset mid-access while tbman is selected.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8000_0004; cpu_be = 4'hF;
        @(posedge clk); #1;
        chk("mid_pre_cs_tbman", cs_tbman_n, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_cs", {cs_timer_n, cs_tbman_n, cs_dmem_n}, 3'b111);
        chk("mid_reset_ready", cpu_ready, 1'b0);
        chk("mid_reset_rdata", cpu_rdata, 32'h0);
        chk("mid_reset_bus", {bus_we, bus_addr}, 33'h0);
        cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_idle", {cpu_ready, cs_timer_n, cs_tbman_n, cs_dmem_n}, 4'b0111);
        do_access("post_reset_dmem", 32'h0000_0004, 1'b0, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dbus_ctrl.md
Name: dbus_ctrl

Overview:
Data-bus controller between the CPU load/store port and the data-side slaves: data memory, tbman and timer.
- Decodes the CPU address and drives the active-low chip selects (cs_dmem_n, cs_tbman_n, cs_timer_n) that feed the read-data mux.
- Inserts per-slave wait states and registers the returned read data.
- Acknowledges the CPU with a one-cycle ready pulse; the CPU stalls while ready is low.
- Flags accesses to unmapped addresses.

Parameters:
DMEM_BASE, 32'h0000_0000, dmem region base
DMEM_MASK, 32'hFFFF_C000, dmem hit when (addr & DMEM_MASK) == DMEM_BASE (16 KB)
TBMAN_BASE, 32'h8000_0000, tbman page base
TIMER_BASE, 32'h8000_1000, timer page base
PERIPH_MASK, 32'hFFFF_F000, page mask for tbman/timer (4 KB pages)
DMEM_WS, 0, dmem wait states (0..15)
TBMAN_WS, 1, tbman wait states (0..15)
TIMER_WS, 2, timer wait states (0..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cpu_req  input  1  access request; held until cpu_ready
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  32  byte address
cpu_wdata  input  32  write data
cpu_be  input  4  byte enables
cpu_ready  output  1  one-cycle completion pulse
cpu_rdata  output  32  registered read data, valid with cpu_ready
cpu_err  output  1  unmapped access, valid with cpu_ready
cs_dmem_n  output  1  dmem select, active low
cs_tbman_n  output  1  tbman select, active low
cs_timer_n  output  1  timer select, active low
bus_we  output  1  write strobe to slaves
bus_addr  output  32  latched address
bus_wdata  output  32  latched write data
bus_be  output  4  latched byte enables
read_data_dmem  input  32  dmem read data
read_data_tbman  input  32  tbman read data
read_data_timer  input  32  timer read data

Behaviour:
- Reset (asynchronous, immediate, including mid-access):
  - state IDLE; all cs_*_n = 1; bus_we = 0; bus_addr/bus_wdata = 0; bus_be = 0.
  - cpu_ready = 0; cpu_rdata = 0; cpu_err = 0; wait counter = 0.
- FSM IDLE:
  - On cpu_req = 1, latch cpu_addr/we/wdata/be into bus_* and decode.
  - Decode priority: dmem > tbman > timer.
  - Hit: load 4-bit counter with the target's WS, record target, go to ACCESS.
  - No hit: set cpu_err = 1 and cpu_rdata = 0, go to RESP; no chip select asserts.
- FSM ACCESS:
  - Exactly the target's cs_*_n = 0; the other selects stay 1. bus_we = latched we.
  - Counter != 0: decrement and stay.
  - Counter == 0: capture the target's read_data_* into cpu_rdata (reads only; writes leave cpu_rdata = 0), then go to RESP.
  - Occupancy is WS+1 cycles.
- FSM RESP:
  - All cs_*_n = 1; bus_we = 0.
  - cpu_ready = 1 for exactly one cycle; cpu_rdata/cpu_err valid in that cycle; go to IDLE.
  - cpu_err clears on leaving RESP. cpu_rdata holds until the next capture.
- Latency: req sampled in IDLE at cycle N; cs low in cycles N+1 .. N+1+WS; cpu_ready at cycle N+2+WS.
  - Unmapped access: cpu_ready at N+1.
- Handshake:
  - The CPU holds cpu_req and inputs stable until cpu_ready.
  - cpu_req seen during RESP is ignored; a new request is sampled in IDLE the following cycle.
  - Back-to-back throughput: one access per WS+3 cycles.
- At most one chip select is low in any cycle. All selects are high in IDLE, in RESP and under reset.
- cpu_req dropping mid-ACCESS (protocol violation): the access completes normally.
- WS parameters are used modulo 16 (4-bit counter).

Test Plan:
- Reset: assert reset in ACCESS with cs_tbman_n = 0 -> all cs_n = 1, cpu_ready = 0, cpu_rdata = 0 immediately; state IDLE after release.
- Dmem read: addr 0x0000_0010, read_data_dmem = 0xDEAD_BEEF -> cs_dmem_n low 1 cycle, cpu_ready at N+2, cpu_rdata = 0xDEAD_BEEF, cpu_err = 0.
- Timer read: addr 0x8000_1004, read_data_timer = 0x0000_1234 -> cs_timer_n low cycles N+1..N+3, cpu_ready at N+4, cpu_rdata = 0x0000_1234.
- Tbman write: addr 0x8000_0000, wdata 0xA5A5_A5A5, be = 4'hF -> cs_tbman_n = 0 and bus_we = 1 for 2 cycles, bus_wdata = 0xA5A5_A5A5, cpu_ready at N+3, cpu_rdata = 0.
- Unmapped: addr 0x4000_0000 read -> no cs asserted, cpu_ready at N+1, cpu_err = 1, cpu_rdata = 0.
- Back-to-back: dmem read then timer read with cpu_req held continuously -> ready pulses 3 cycles then 5 cycles apart, never two cs_n low simultaneously.
